// File: rtl/out_port_alloc.sv
// ---------------------------------------------------------------------------
// out_port_alloc
//
// Wormhole allocator for a single router output port. Input ports request
// the output in one of two classes: multicast (m_req, masked by multab_ct)
// and unicast (u_req). Multicast is preferred. Within each class a
// round-robin pointer decides among the requesters. A unicast age counter
// forces a unicast grant once AGE_MAX multicast grants have gone by while
// unicast traffic was waiting. A winning input holds the output until the
// tail flit of its packet crosses (fire with the owner's tail bit set).
//
// Parameters
//   NPORT    number of input ports (>= 2)
//   AGE_MAX  multicast wins tolerated while unicast waits (>= 1)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_       synchronous, active-high reset
//   u_req      unicast request per input port
//   m_req      multicast request per input port
//   multab_ct  multicast/absorb contention, masks the matching m_req bit
//   tail       head-of-line flit at input i is a tail flit
//   fire       one flit crossed this output port this cycle
//   grt        registered grant, one-hot or zero
//   grt_mc     current grant belongs to the multicast class
//   busy       output port is locked to a packet
//   starve     unicast forcing active (age counter at AGE_MAX)
// ---------------------------------------------------------------------------
module out_port_alloc #(
    parameter int NPORT   = 5,
    parameter int AGE_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [NPORT-1:0] u_req,
    input  logic [NPORT-1:0] m_req,
    input  logic [NPORT-1:0] multab_ct,
    input  logic [NPORT-1:0] tail,
    input  logic             fire,
    output logic [NPORT-1:0] grt,
    output logic             grt_mc,
    output logic             busy,
    output logic             starve
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int AW = (AGE_MAX > 1) ? $clog2(AGE_MAX + 1) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [PW-1:0] LAST_PORT = PW'(NPORT - 1);
    localparam logic [AW-1:0] AGE_TOP   = AW'(AGE_MAX);

    logic [0:0]       state;
    logic [PW-1:0]    rr_u;
    logic [PW-1:0]    rr_m;
    logic [AW-1:0]    age;

    logic [NPORT-1:0] em;
    logic [NPORT-1:0] eu;
    logic             pick_mc;
    logic             pick_uc;
    logic             grant_now;
    logic             pkt_done;
    logic [PW-1:0]    win_m;
    logic [PW-1:0]    win_u;
    logic [PW-1:0]    win;
    logic [PW-1:0]    win_next;
    logic [NPORT-1:0] win_onehot;

    // First set bit of req, scanning upward from ptr and wrapping at NPORT-1.
    // Returns 0 when req is empty; callers only use it with a non-empty set.
    function automatic logic [PW-1:0] rr_pick(input logic [NPORT-1:0] req,
                                              input logic [PW-1:0]    ptr);
        logic [PW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NPORT) begin
                idx = idx - NPORT;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
        return pick;
    endfunction

    // Eligible sets. Contention only suppresses the multicast request of a
    // port; a unicast request on the same port stays eligible.
    assign em = m_req & ~multab_ct;
    assign eu = u_req;

    assign starve = (age == AGE_TOP);
    assign busy   = (state == ST_LOCKED);

    // Class selection and winner computation. Both round-robin scans run in
    // parallel and the class decision picks one result, so a port that
    // requests in both classes can only ever receive one grant.
    always_comb begin
        pick_mc    = 1'b0;
        pick_uc    = 1'b0;
        grant_now  = 1'b0;
        win_m      = rr_pick(em, rr_m);
        win_u      = rr_pick(eu, rr_u);
        win        = win_u;
        win_next   = '0;
        win_onehot = '0;

        if ((|em) && !starve) begin
            pick_mc = 1'b1;
        end else if (|eu) begin
            pick_uc = 1'b1;
        end

        grant_now = (state == ST_IDLE) && (pick_mc || pick_uc);

        if (pick_mc) begin
            win = win_m;
        end

        if (win == LAST_PORT) begin
            win_next = '0;
        end else begin
            win_next = win + PW'(1);
        end

        win_onehot[win] = 1'b1;
    end

    // The packet ends when a flit fires and the owning input's head flit is
    // a tail. Tail bits of other inputs are ignored by the grant mask.
    assign pkt_done = (state == ST_LOCKED) && fire && (|(tail & grt));

    // Grant lock: IDLE arbitrates, LOCKED holds the grant untouched until
    // the owner's tail crosses, giving one idle bubble between packets.
    always_ff @(posedge clk) begin
        if (rst_) begin
            state  <= ST_IDLE;
            grt    <= '0;
            grt_mc <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_now) begin
                        state  <= ST_LOCKED;
                        grt    <= win_onehot;
                        grt_mc <= pick_mc;
                    end
                end
                ST_LOCKED: begin
                    if (pkt_done) begin
                        state  <= ST_IDLE;
                        grt    <= '0;
                        grt_mc <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    grt    <= '0;
                    grt_mc <= 1'b0;
                end
            endcase
        end
    end

    // Round-robin pointers advance past the winner of their own class only;
    // the other class keeps its position.
    always_ff @(posedge clk) begin
        if (rst_) begin
            rr_u <= '0;
            rr_m <= '0;
        end else if (grant_now) begin
            if (pick_mc) begin
                rr_m <= win_next;
            end else begin
                rr_u <= win_next;
            end
        end
    end

    // Unicast age: counts multicast grants issued while unicast is waiting.
    // Cleared as soon as unicast stops requesting or wins a grant, and
    // saturates at AGE_MAX, where it forces the next arbitration to unicast.
    always_ff @(posedge clk) begin
        if (rst_) begin
            age <= '0;
        end else if (u_req == '0) begin
            age <= '0;
        end else if (grant_now && pick_uc) begin
            age <= '0;
        end else if (grant_now && pick_mc && (age != AGE_TOP)) begin
            age <= age + AW'(1);
        end
    end

endmodule

// File: tb/tb_out_port_alloc.sv
// ---------------------------------------------------------------------------
// tb_out_port_alloc
//
// Directed bench for out_port_alloc with NPORT=5 and AGE_MAX=3. Each step
// drives the inputs, advances one rising edge and samples the registered
// outputs 1ns later against hand-computed values.
// ---------------------------------------------------------------------------
module tb_out_port_alloc;

    localparam int NPORT   = 5;
    localparam int AGE_MAX = 3;

    logic             clk;
    logic             rst_;
    logic [NPORT-1:0] u_req;
    logic [NPORT-1:0] m_req;
    logic [NPORT-1:0] multab_ct;
    logic [NPORT-1:0] tail;
    logic             fire;
    logic [NPORT-1:0] grt;
    logic             grt_mc;
    logic             busy;
    logic             starve;

    int compareCount;
    int mismatchCount;

    out_port_alloc #(
        .NPORT   (NPORT),
        .AGE_MAX (AGE_MAX)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .u_req     (u_req),
        .m_req     (m_req),
        .multab_ct (multab_ct),
        .tail      (tail),
        .fire      (fire),
        .grt       (grt),
        .grt_mc    (grt_mc),
        .busy      (busy),
        .starve    (starve)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0b expected %0b", tag, observed, expected);
        end
    endtask

    // Drive one set of inputs, take one rising edge, settle past the edge.
    task automatic applyStimulus(input logic [NPORT-1:0] u, input logic [NPORT-1:0] m,
                                 input logic [NPORT-1:0] mct, input logic [NPORT-1:0] tl,
                                 input logic f);
        u_req     = u;
        m_req     = m;
        multab_ct = mct;
        tail      = tl;
        fire      = f;
        @(posedge clk);
        #1;
    endtask

    task automatic expectState(input string tag, input logic [NPORT-1:0] g,
                               input logic mc, input logic b, input logic s);
        checkOutput({tag, ".grt"},    32'(grt),    32'(g));
        checkOutput({tag, ".grt_mc"}, 32'(grt_mc), 32'(mc));
        checkOutput({tag, ".busy"},   32'(busy),   32'(b));
        checkOutput({tag, ".starve"}, 32'(starve), 32'(s));
    endtask

    task automatic doReset();
        rst_ = 1'b1;
        applyStimulus('0, '0, '0, '0, 1'b0);
        applyStimulus('0, '0, '0, '0, 1'b0);
        rst_ = 1'b0;
    endtask

    logic [NPORT-1:0] rrExpect [7];

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rst_      = 1'b1;
        u_req     = '0;
        m_req     = '0;
        multab_ct = '0;
        tail      = '0;
        fire      = 1'b0;

        // Reset state, then a reset that lands while a packet is locked.
        doReset();
        expectState("reset", 5'b00000, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'b00100, '0, '0, '0, 1'b0);
        expectState("lock_c1", 5'b00100, 1'b0, 1'b1, 1'b0);
        applyStimulus(5'b00100, '0, '0, '0, 1'b0);
        expectState("lock_c2", 5'b00100, 1'b0, 1'b1, 1'b0);
        rst_ = 1'b1;
        applyStimulus(5'b00100, '0, '0, '0, 1'b0);
        rst_ = 1'b0;
        expectState("lock_drop", 5'b00000, 1'b0, 1'b0, 1'b0);
        // rr_u must be back at 0, so port 0 beats port 4.
        applyStimulus(5'b10001, '0, '0, '0, 1'b0);
        expectState("after_rst", 5'b00001, 1'b0, 1'b1, 1'b0);
        applyStimulus(5'b10001, '0, '0, 5'b00001, 1'b1);
        expectState("after_rst_rel", 5'b00000, 1'b0, 1'b0, 1'b0);

        // Unicast round-robin with single-flit packets.
        doReset();
        rrExpect[0] = 5'b00001;
        rrExpect[1] = 5'b00000;
        rrExpect[2] = 5'b00100;
        rrExpect[3] = 5'b00000;
        rrExpect[4] = 5'b10000;
        rrExpect[5] = 5'b00000;
        rrExpect[6] = 5'b00001;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(5'b10101, '0, '0, 5'b11111, 1'b1);
            checkOutput($sformatf("rr_u_c%0d", i + 1), 32'(grt), 32'(rrExpect[i]));
            checkOutput($sformatf("rr_u_mc_c%0d", i + 1), 32'(grt_mc), 32'(0));
        end

        // Contention masks the multicast request, unicast wins meanwhile.
        doReset();
        applyStimulus(5'b00010, 5'b10000, 5'b10000, '0, 1'b0);
        expectState("mask_uc", 5'b00010, 1'b0, 1'b1, 1'b0);
        applyStimulus(5'b00010, 5'b10000, 5'b10000, 5'b00010, 1'b1);
        expectState("mask_rel", 5'b00000, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'b00010, 5'b10000, '0, '0, 1'b0);
        expectState("mc_prio", 5'b10000, 1'b1, 1'b1, 1'b0);

        // Wormhole hold: non-tail fires and foreign tails keep the lock.
        doReset();
        applyStimulus(5'b01000, '0, '0, '0, 1'b0);
        expectState("hold_grant", 5'b01000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(5'b01000, 5'b10001, '0, 5'b00000, 1'b1);
            checkOutput($sformatf("hold_c%0d", i), 32'(grt), 32'(5'b01000));
        end
        applyStimulus(5'b00000, 5'b10001, '0, 5'b10111, 1'b1);
        expectState("hold_foreign_tail", 5'b01000, 1'b0, 1'b1, 1'b0);
        applyStimulus(5'b00000, 5'b10001, '0, 5'b01000, 1'b1);
        expectState("hold_rel", 5'b00000, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'b00000, 5'b10001, '0, 5'b00000, 1'b0);
        expectState("hold_next_mc", 5'b00001, 1'b1, 1'b1, 1'b0);

        // Starvation: three multicast wins push age to AGE_MAX=3.
        doReset();
        applyStimulus(5'b00100, 5'b00011, '0, 5'b11111, 1'b1);
        expectState("stv_mc0", 5'b00001, 1'b1, 1'b1, 1'b0);
        applyStimulus(5'b00100, 5'b00011, '0, 5'b11111, 1'b1);
        expectState("stv_gap1", 5'b00000, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'b00100, 5'b00011, '0, 5'b11111, 1'b1);
        expectState("stv_mc1", 5'b00010, 1'b1, 1'b1, 1'b0);
        applyStimulus(5'b00100, 5'b00011, '0, 5'b11111, 1'b1);
        applyStimulus(5'b00100, 5'b00011, '0, 5'b11111, 1'b1);
        expectState("stv_mc2", 5'b00001, 1'b1, 1'b1, 1'b1);
        applyStimulus(5'b00100, 5'b00011, '0, 5'b11111, 1'b1);
        expectState("stv_gap3", 5'b00000, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'b00100, 5'b00011, '0, 5'b11111, 1'b1);
        expectState("stv_force_uc", 5'b00100, 1'b0, 1'b1, 1'b0);
        applyStimulus(5'b00100, 5'b00011, '0, 5'b11111, 1'b1);
        applyStimulus(5'b00100, 5'b00011, '0, 5'b11111, 1'b1);
        expectState("stv_mc_resume", 5'b00010, 1'b1, 1'b1, 1'b0);

        // Multicast pointer wrap: win at port 3 leaves rr_m=4.
        doReset();
        applyStimulus('0, 5'b01000, '0, 5'b11111, 1'b1);
        expectState("wrap_mc3", 5'b01000, 1'b1, 1'b1, 1'b0);
        applyStimulus('0, 5'b01001, '0, 5'b11111, 1'b1);
        checkOutput("wrap_gap", 32'(grt), 32'(5'b00000));
        applyStimulus('0, 5'b01001, '0, 5'b11111, 1'b1);
        expectState("wrap_mc0", 5'b00001, 1'b1, 1'b1, 1'b0);
        applyStimulus('0, 5'b01001, '0, 5'b11111, 1'b1);
        applyStimulus('0, 5'b01001, '0, 5'b11111, 1'b1);
        expectState("wrap_ptr1", 5'b01000, 1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
